// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions for the ID/EX stage: opcode/funct codes,
// ALU operation encodings and the ID/EX pipeline-register layout.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_LUI = 4'd6
    } alu_op_t;

    typedef struct packed {
        logic        valid;
        logic        reg_we;
        logic        mem_we;
        logic        mem_to_reg;
        logic        alu_src;
        logic        reg_dst;
        logic        branch;
        logic        illegal;
        alu_op_t     alu_op;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } id_ex_t;

    localparam id_ex_t ID_EX_BUBBLE = '0;

    // Instructions that read rt as a source operand (rather than writing it).
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/ext_unit.sv
// 16-to-32-bit immediate extender: zero extension when ext_zero0_sign1=0,
// sign extension when ext_zero0_sign1=1.
module ext_unit (
    input  logic        ext_zero0_sign1,
    input  logic [15:0] a,
    output logic [31:0] y
);

    assign y = {{16{ext_zero0_sign1 & a[15]}}, a};

endmodule

// File: rtl/id_ex_stage.sv
// MIPS ID decode plus ID/EX pipeline register with load-use hazard detect.
// Optional bubble counter output enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_d,
    input  logic        valid_d,
    input  logic [31:0] pc4_d,
    input  logic [31:0] rd1_d,
    input  logic [31:0] rd2_d,
    input  logic        stall_e,
    input  logic        flush_e,
    output logic        valid_e,
    output logic        reg_we_e,
    output logic        mem_we_e,
    output logic        mem_to_reg_e,
    output logic        alu_src_e,
    output logic        reg_dst_e,
    output logic        branch_e,
    output logic        illegal_e,
    output logic [3:0]  alu_op_e,
    output logic [31:0] rd1_e,
    output logic [31:0] rd2_e,
    output logic [31:0] imm_e,
    output logic [31:0] pc4_e,
    output logic [4:0]  rs_e,
    output logic [4:0]  rt_e,
    output logic [4:0]  rd_e,
    output logic        lu_hazard_d
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0] bubble_cnt
`endif
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic        ext_sign;
    logic [31:0] imm_ext;
    id_ex_t      dec;
    id_ex_t      load_val;
    id_ex_t      q;

    assign op    = instr_d[31:26];
    assign funct = instr_d[5:0];

    assign ext_sign = !((op == OP_ANDI) || (op == OP_ORI) ||
                        (op == OP_XORI) || (op == OP_LUI));

    ext_unit u_ext (
        .ext_zero0_sign1 (ext_sign),
        .a               (instr_d[15:0]),
        .y               (imm_ext)
    );

    // NOTE: every field gets a default before the case so no path leaves a
    // field unassigned and no latch is inferred.
    always_comb begin
        dec        = ID_EX_BUBBLE;
        dec.valid  = 1'b1;
        dec.alu_op = ALU_ADD;
        dec.rd1    = rd1_d;
        dec.rd2    = rd2_d;
        dec.pc4    = pc4_d;
        dec.rs     = instr_d[25:21];
        dec.rt     = instr_d[20:16];
        dec.rd     = instr_d[15:11];
        case (op)
            OP_RTYPE: begin
                dec.reg_we  = 1'b1;
                dec.reg_dst = 1'b1;
                case (funct)
                    FN_ADD:  dec.alu_op = ALU_ADD;
                    FN_SUB:  dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    default: begin
                        dec.illegal = 1'b1;
                        dec.reg_we  = 1'b0;
                        dec.reg_dst = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                dec.reg_we  = 1'b1;
                dec.alu_src = 1'b1;
            end
            OP_SLTI: begin
                dec.reg_we  = 1'b1;
                dec.alu_src = 1'b1;
                dec.alu_op  = ALU_SLT;
            end
            OP_ANDI: begin
                dec.reg_we  = 1'b1;
                dec.alu_src = 1'b1;
                dec.alu_op  = ALU_AND;
            end
            OP_ORI: begin
                dec.reg_we  = 1'b1;
                dec.alu_src = 1'b1;
                dec.alu_op  = ALU_OR;
            end
            OP_XORI: begin
                dec.reg_we  = 1'b1;
                dec.alu_src = 1'b1;
                dec.alu_op  = ALU_XOR;
            end
            OP_LUI: begin
                // The immediate stays unshifted; the ALU applies the <<16.
                dec.reg_we  = 1'b1;
                dec.alu_src = 1'b1;
                dec.alu_op  = ALU_LUI;
            end
            OP_LW: begin
                dec.reg_we     = 1'b1;
                dec.alu_src    = 1'b1;
                dec.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                dec.mem_we  = 1'b1;
                dec.alu_src = 1'b1;
            end
            OP_BEQ: begin
                dec.branch = 1'b1;
                dec.alu_op = ALU_SUB;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    always_comb begin
        load_val     = dec;
        load_val.imm = imm_ext;
        if (!valid_d)
            load_val = ID_EX_BUBBLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= ID_EX_BUBBLE;
        else if (flush_e)
            q <= ID_EX_BUBBLE;
        else if (!stall_e)
            q <= load_val;
    end

    assign valid_e      = q.valid;
    assign reg_we_e     = q.reg_we;
    assign mem_we_e     = q.mem_we;
    assign mem_to_reg_e = q.mem_to_reg;
    assign alu_src_e    = q.alu_src;
    assign reg_dst_e    = q.reg_dst;
    assign branch_e     = q.branch;
    assign illegal_e    = q.illegal;
    assign alu_op_e     = q.alu_op;
    assign rd1_e        = q.rd1;
    assign rd2_e        = q.rd2;
    assign imm_e        = q.imm;
    assign pc4_e        = q.pc4;
    assign rs_e         = q.rs;
    assign rt_e         = q.rt;
    assign rd_e         = q.rd;

    assign lu_hazard_d = !rst && q.valid && q.mem_to_reg && (q.rt != 5'd0) &&
                         ((q.rt == instr_d[25:21]) ||
                          ((q.rt == instr_d[20:16]) && uses_rt(op)));

`ifdef ID_EX_PERF_CNT_EN
    logic bubble_cap;

    // A flush always captures a bubble; an invalid ID slot only when not stalled.
    assign bubble_cap = flush_e || (!stall_e && !valid_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bubble_cnt <= '0;
        else if (bubble_cap && (bubble_cnt != 32'hFFFF_FFFF))
            bubble_cnt <= bubble_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: behavioural model plus literal checks.
// Exercises bubble_cnt as well when ID_EX_PERF_CNT_EN is defined.
module tb_id_ex_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr_d = '0;
    logic        valid_d = 1'b0;
    logic [31:0] pc4_d = '0;
    logic [31:0] rd1_d = '0;
    logic [31:0] rd2_d = '0;
    logic        stall_e = 1'b0;
    logic        flush_e = 1'b0;
    logic        valid_e, reg_we_e, mem_we_e, mem_to_reg_e;
    logic        alu_src_e, reg_dst_e, branch_e, illegal_e;
    logic [3:0]  alu_op_e;
    logic [31:0] rd1_e, rd2_e, imm_e, pc4_e;
    logic [4:0]  rs_e, rt_e, rd_e;
    logic        lu_hazard_d;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    id_ex_stage dut (
        .clk          (clk),
        .rst          (rst),
        .instr_d      (instr_d),
        .valid_d      (valid_d),
        .pc4_d        (pc4_d),
        .rd1_d        (rd1_d),
        .rd2_d        (rd2_d),
        .stall_e      (stall_e),
        .flush_e      (flush_e),
        .valid_e      (valid_e),
        .reg_we_e     (reg_we_e),
        .mem_we_e     (mem_we_e),
        .mem_to_reg_e (mem_to_reg_e),
        .alu_src_e    (alu_src_e),
        .reg_dst_e    (reg_dst_e),
        .branch_e     (branch_e),
        .illegal_e    (illegal_e),
        .alu_op_e     (alu_op_e),
        .rd1_e        (rd1_e),
        .rd2_e        (rd2_e),
        .imm_e        (imm_e),
        .pc4_e        (pc4_e),
        .rs_e         (rs_e),
        .rt_e         (rt_e),
        .rd_e         (rd_e),
        .lu_hazard_d  (lu_hazard_d)
`ifdef ID_EX_PERF_CNT_EN
        ,
        .bubble_cnt   (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected contents of the ID/EX register.
    typedef struct packed {
        logic        valid;
        logic        reg_we;
        logic        mem_we;
        logic        mem_to_reg;
        logic        alu_src;
        logic        reg_dst;
        logic        branch;
        logic        illegal;
        logic [3:0]  alu_op;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } exp_t;

    // Per-instruction control word {reg_we, mem_we, mem_to_reg, alu_src,
    // reg_dst, branch, zero_ext} followed by the ALU op; zero word = illegal.
    function automatic exp_t predict(input logic [31:0] ins, input logic [31:0] a,
                                     input logic [31:0] b, input logic [31:0] p);
        exp_t        e;
        logic [10:0] ctl;
        logic        bad;
        e   = '0;
        bad = 1'b0;
        ctl = '0;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20:   ctl = {7'b1000100, ALU_ADD};
                6'h22:   ctl = {7'b1000100, ALU_SUB};
                6'h24:   ctl = {7'b1000100, ALU_AND};
                6'h25:   ctl = {7'b1000100, ALU_OR};
                6'h2A:   ctl = {7'b1000100, ALU_SLT};
                default: bad = 1'b1;
            endcase
            6'h08, 6'h09: ctl = {7'b1001000, ALU_ADD};
            6'h0A:        ctl = {7'b1001000, ALU_SLT};
            6'h0C:        ctl = {7'b1001001, ALU_AND};
            6'h0D:        ctl = {7'b1001001, ALU_OR};
            6'h0E:        ctl = {7'b1001001, ALU_XOR};
            6'h0F:        ctl = {7'b1001001, ALU_LUI};
            6'h23:        ctl = {7'b1011000, ALU_ADD};
            6'h2B:        ctl = {7'b0101000, ALU_ADD};
            6'h04:        ctl = {7'b0000010, ALU_SUB};
            default:      bad = 1'b1;
        endcase
        e.valid      = 1'b1;
        e.illegal    = bad;
        e.reg_we     = ctl[10];
        e.mem_we     = ctl[9];
        e.mem_to_reg = ctl[8];
        e.alu_src    = ctl[7];
        e.reg_dst    = ctl[6];
        e.branch     = ctl[5];
        e.alu_op     = ctl[3:0];
        e.imm        = ctl[4] ? {16'h0000, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
        e.rd1        = a;
        e.rd2        = b;
        e.pc4        = p;
        e.rs         = ins[25:21];
        e.rt         = ins[20:16];
        e.rd         = ins[15:11];
        return e;
    endfunction

    exp_t        m = '0;
    logic [31:0] m_cnt = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m     <= '0;
            m_cnt <= '0;
        end else begin
            if (flush_e)
                m <= '0;
            else if (!stall_e)
                m <= valid_d ? predict(instr_d, rd1_d, rd2_d, pc4_d) : '0;
            if ((flush_e || (!stall_e && !valid_d)) && m_cnt != 32'hFFFF_FFFF)
                m_cnt <= m_cnt + 1;
        end
    end

    function automatic logic exp_hazard();
        logic [5:0] o;
        logic       rt_src;
        o      = instr_d[31:26];
        rt_src = (o == 6'h00) || (o == 6'h2B) || (o == 6'h04);
        return !rst && m.valid && m.mem_to_reg && (m.rt != 0) &&
               ((m.rt == instr_d[25:21]) || ((m.rt == instr_d[20:16]) && rt_src));
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("valid_e",      valid_e,      m.valid);
            check("reg_we_e",     reg_we_e,     m.reg_we);
            check("mem_we_e",     mem_we_e,     m.mem_we);
            check("mem_to_reg_e", mem_to_reg_e, m.mem_to_reg);
            check("alu_src_e",    alu_src_e,    m.alu_src);
            check("reg_dst_e",    reg_dst_e,    m.reg_dst);
            check("branch_e",     branch_e,     m.branch);
            check("illegal_e",    illegal_e,    m.illegal);
            check("alu_op_e",     alu_op_e,     m.alu_op);
            check("rd1_e",        rd1_e,        m.rd1);
            check("rd2_e",        rd2_e,        m.rd2);
            check("imm_e",        imm_e,        m.imm);
            check("pc4_e",        pc4_e,        m.pc4);
            check("rs_e",         rs_e,         m.rs);
            check("rt_e",         rt_e,         m.rt);
            check("rd_e",         rd_e,         m.rd);
            check("lu_hazard_d",  lu_hazard_d,  exp_hazard());
`ifdef ID_EX_PERF_CNT_EN
            check("bubble_cnt",   bubble_cnt,   m_cnt);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins);
        instr_d = ins;
        valid_d = 1'b1;
        rd1_d   = $urandom;
        rd2_d   = $urandom;
        pc4_d   = $urandom;
        stall_e = 1'b0;
        flush_e = 1'b0;
    endtask

    logic [5:0] op_pool[14] = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D,
                                6'h0E, 6'h0F, 6'h23, 6'h23, 6'h2B, 6'h04, 6'h3F};
    logic [5:0] fn_pool[6]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h07};

    initial begin
        #1 rst = 1'b1;
        #1;
        check("reset_valid_e", valid_e, 1'b0);
        check("reset_imm_e", imm_e, 32'h0);
        check("reset_hazard", lu_hazard_d, 1'b0);
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        drive(32'h2008FFFF);
        step();
        check("addi_imm", imm_e, 32'hFFFF_FFFF);
        check("addi_alu_src", alu_src_e, 1'b1);
        check("addi_reg_we", reg_we_e, 1'b1);
        check("addi_alu_op", alu_op_e, ALU_ADD);
        check("addi_rt", rt_e, 5'd8);

        drive(32'h3108FFFF);
        step();
        check("andi_imm", imm_e, 32'h0000_FFFF);
        check("andi_alu_op", alu_op_e, ALU_AND);

        drive(32'h3C081234);
        step();
        check("lui_imm", imm_e, 32'h0000_1234);
        check("lui_alu_op", alu_op_e, ALU_LUI);

        drive(32'h8C090004);
        step();
        instr_d = 32'h01095020;
        #1;
        check("lw_add_hazard", lu_hazard_d, 1'b1);
        drive(32'h8C000004);
        step();
        instr_d = 32'h00005020;
        #1;
        check("lw_rt0_hazard", lu_hazard_d, 1'b0);

        drive(32'h2008FFFF);
        step();
        stall_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr_d = $urandom;
            rd1_d   = $urandom;
            step();
            check("stall_imm", imm_e, 32'hFFFF_FFFF);
            check("stall_rt", rt_e, 5'd8);
            check("stall_valid", valid_e, 1'b1);
        end
        flush_e = 1'b1;
        step();
        check("stall_flush_valid", valid_e, 1'b0);
        check("stall_flush_reg_we", reg_we_e, 1'b0);

        drive(32'hFC000000);
        step();
        check("illegal_flag", illegal_e, 1'b1);
        check("illegal_reg_we", reg_we_e, 1'b0);
        check("illegal_mem_we", mem_we_e, 1'b0);
        check("illegal_valid", valid_e, 1'b1);

        drive(32'h2008FFFF);
        step();
        stall_e = 1'b1;
        rst = 1'b1;
        #1;
        check("async_rst_valid", valid_e, 1'b0);
        check("async_rst_reg_we", reg_we_e, 1'b0);
        check("async_rst_imm", imm_e, 32'h0);
        rst = 1'b0;
        stall_e = 1'b0;

`ifdef ID_EX_PERF_CNT_EN
        rst = 1'b1;
        #1 rst = 1'b0;
        flush_e = 1'b1;
        repeat (5) step();
        flush_e = 1'b0;
        stall_e = 1'b1;
        repeat (2) step();
        check("perf_cnt_5", bubble_cnt, 32'd5);
        stall_e = 1'b0;
`endif

        for (int n = 0; n < 600; n++) begin
            logic [31:0] ins;
            logic [5:0]  o;
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b1;
                #1;
                check("rand_async_rst", valid_e, 1'b0);
                rst = 1'b0;
            end
            ins = $urandom;
            o   = op_pool[$urandom_range(0, 13)];
            ins[31:26] = o;
            ins[25:21] = 5'($urandom_range(0, 3));
            ins[20:16] = 5'($urandom_range(0, 3));
            if (o == 6'h00 && $urandom_range(0, 3) != 0)
                ins[5:0] = fn_pool[$urandom_range(0, 5)];
            drive(ins);
            valid_d = ($urandom_range(0, 9) != 0);
            stall_e = ($urandom_range(0, 6) == 0);
            flush_e = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have the ports clk (input, 1 bit, rising-edge clock) and rst (input, 1 bit); one clock, and reset is asynchronous and active-high.
REQ-002 The block SHALL have the port instr_d (input, 32 bits): the instruction in ID.
REQ-003 The block SHALL have the ports valid_d (input, 1 bit, instr_d valid) and pc4_d (input, 32 bits, PC+4 of instr_d).
REQ-004 The block SHALL have the ports rd1_d and rd2_d (input, 32 bits each): register-file reads for rs and rt.
REQ-005 The block SHALL have the port stall_e (input, 1 bit): hold the ID/EX register.
REQ-006 The block SHALL have the port flush_e (input, 1 bit): load a bubble into the ID/EX register.
REQ-007 The block SHALL have the ports valid_e, reg_we_e, mem_we_e, mem_to_reg_e, alu_src_e, reg_dst_e, branch_e and illegal_e (output, 1 bit each): registered EX controls.
REQ-008 The block SHALL have the port alu_op_e (output, 4 bits): the registered ALU operation code.
REQ-009 The block SHALL have the ports rd1_e, rd2_e, imm_e and pc4_e (output, 32 bits each): registered data.
REQ-010 The block SHALL have the ports rs_e, rt_e and rd_e (output, 5 bits each): registered register specifiers.
REQ-011 The block SHALL have the port lu_hazard_d (output, 1 bit, combinational): load-use hazard request to the stall logic.

Function
REQ-012 Decode SHALL cover R-type 000000 (funct add/sub/and/or/slt) plus addi, addiu, slti, andi, ori, xori, lui, lw, sw and beq.
REQ-013 The extension mode SHALL be sign for addi, addiu, slti, lw, sw and beq, and zero for andi, ori, xori and lui.
REQ-014 Extension SHALL be fed to the extender with ext_zero0_sign1 and a = instr_d[15:0]; its 32-bit y is captured as imm_e.
REQ-015 For lui, imm_e SHALL hold the zero-extended value unshifted; alu_op_e = LUI and the ALU performs the <<16.
REQ-016 An unknown opcode, or an unknown funct for R-type, SHALL capture illegal_e=1 with reg_we_e=0 and mem_we_e=0; valid_e follows valid_d.
REQ-017 The register SHALL update on each rising clk; priority is flush_e > stall_e > load.
REQ-018 On flush_e the register SHALL capture a bubble: valid_e, reg_we_e, mem_we_e, branch_e and illegal_e become 0; other fields are don't-care but are driven to 0.
REQ-019 On stall_e without flush_e, all outputs SHALL hold their values.
REQ-020 With valid_d=0 on a load cycle, the register SHALL capture a bubble identical to the flush bubble.
REQ-021 lu_hazard_d SHALL be 1 iff valid_e & mem_to_reg_e & (rt_e != 0) & (rt_e == instr_d[25:21] | (rt_e == instr_d[20:16] & instr_d uses rt as a source)).
REQ-022 lu_hazard_d SHALL be 0 while rst is asserted.
REQ-023 Latency SHALL be one cycle from ID inputs to the _e outputs.
REQ-024 The decode SHALL be purely combinational ahead of the register; there is no multi-cycle state.

Reset
REQ-025 Asserting rst SHALL immediately clear every _e output to 0, independent of clk.
REQ-026 Reset SHALL override flush_e and stall_e, and a reset asserted mid-stall SHALL discard the held instruction.
REQ-027 On the first rising clk after rst deasserts, normal loading SHALL resume.

Configuration
REQ-028 With ID_EX_PERF_CNT_EN defined, the output bubble_cnt (32 bits) SHALL exist and increment, saturating at 0xFFFFFFFF, on each clk edge that captures a bubble (flush or valid_d=0).
REQ-029 bubble_cnt SHALL hold during stall_e and reset to 0.
REQ-030 Without ID_EX_PERF_CNT_EN, the bubble_cnt port and its logic SHALL be absent.

Structure
REQ-031 A shared package mips_pkg SHALL hold the opcode/funct localparams, the alu_op encodings (ADD, SUB, AND, OR, XOR, SLT, LUI) and the bubble constant.
REQ-032 ext_unit SHALL be the single instantiated sub-module; the decoder and the register stay in id_ex_stage.

Verification
REQ-033 addi 0x2008FFFF, valid_d=1 -> next edge: imm_e=0xFFFFFFFF, alu_src_e=1, reg_we_e=1, alu_op_e=ADD, rt_e=8.
REQ-034 andi 0x3108FFFF -> imm_e=0x0000FFFF, alu_op_e=AND; lui 0x3C081234 -> imm_e=0x00001234, alu_op_e=LUI.
REQ-035 lw 0x8C090004 loaded, then ID holds add 0x01095020 -> lu_hazard_d=1; with rt of the lw = 0 -> lu_hazard_d=0.
REQ-036 stall_e=1 for 3 cycles with changing instr_d -> outputs constant; stall_e=1 with flush_e=1 -> bubble (valid_e=0, reg_we_e=0).
REQ-037 Opcode 0x3F -> illegal_e=1, reg_we_e=0, mem_we_e=0; rst pulsed between clk edges -> all outputs 0 before the next edge.
REQ-038 With ID_EX_PERF_CNT_EN defined, 5 flush cycles followed by 2 stall cycles -> bubble_cnt=5.
